// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the set-associative data cache.
// Holds the controller state enum, derived field widths and line address helper.
package dcache_pkg;

  localparam int LINE_BITS_D = 256;
  localparam int SETS_D      = 16;
  localparam int ADDR_W_D    = 32;

  localparam int OFFSET_W   = $clog2(LINE_BITS_D / 8);
  localparam int INDEX_W    = $clog2(SETS_D);
  localparam int TAG_W      = ADDR_W_D - INDEX_W - OFFSET_W;
  localparam int WORD_SEL_W = OFFSET_W - 2;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    WB_GAP,
    REFILL,
    FILL_DONE
  } state_t;

  // Line-aligned byte address {tag, index, 0}; widths default to
  // the package geometry, callers with other geometry pass their own.
  function automatic logic [63:0] line_addr(
    input logic [63:0] tag,
    input logic [63:0] index,
    input int          idx_w = INDEX_W,
    input int          off_w = OFFSET_W
  );
    return (tag << (idx_w + off_w)) | (index << off_w);
  endfunction

endpackage

// File: rtl/dcache_victim_sel.sv
// Per-set replacement state and victim choice for the data cache.
// Ports: clk, rst_n, look_set/valid_vec (victim query + hit update set),
// hit_en/hit_way, fill_en/fill_set/fill_way, victim.
// DCACHE_LRU_EN selects true LRU; otherwise a refill-driven round robin.
module dcache_victim_sel #(
  parameter int WAYS  = 2,
  parameter int SETS  = 16,
  parameter int WAY_W = 1,
  parameter int IDX_B = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_B-1:0] look_set,
  input  logic [WAYS-1:0]  valid_vec,
  input  logic             hit_en,
  input  logic [WAY_W-1:0] hit_way,
  input  logic             fill_en,
  input  logic [IDX_B-1:0] fill_set,
  input  logic [WAY_W-1:0] fill_way,
  output logic [WAY_W-1:0] victim
);
  import dcache_pkg::*;

  logic [WAY_W-1:0] pol_way;

`ifdef DCACHE_LRU_EN
  // Ages form a permutation per set: 0 = most recent.
  logic [WAY_W-1:0] age_q [SETS][WAYS];
  logic             upd_en;
  logic [IDX_B-1:0] upd_set;
  logic [WAY_W-1:0] upd_way;
  logic [WAY_W-1:0] ref_age;

  always_comb begin
    upd_en  = fill_en | hit_en;
    upd_set = fill_en ? fill_set : look_set;
    upd_way = fill_en ? fill_way : hit_way;
    ref_age = age_q[upd_set][upd_way];
    pol_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (age_q[look_set][w] == WAY_W'(WAYS - 1))
        pol_way = WAY_W'(w);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= WAY_W'(w);
    end else if (upd_en) begin
      for (int w = 0; w < WAYS; w++)
        if (WAY_W'(w) == upd_way)
          age_q[upd_set][w] <= '0;
        else if (age_q[upd_set][w] < ref_age)
          age_q[upd_set][w] <= age_q[upd_set][w] + 1'b1;
    end
  end
`else
  logic [WAY_W-1:0] ptr_q [SETS];
  logic             unused_hit;

  // Hits never move the pointer.
  assign unused_hit = ^{hit_en, hit_way};
  assign pol_way    = ptr_q[look_set];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++)
        ptr_q[s] <= '0;
    end else if (fill_en) begin
      if (ptr_q[fill_set] == WAY_W'(WAYS - 1))
        ptr_q[fill_set] <= '0;
      else
        ptr_q[fill_set] <= ptr_q[fill_set] + 1'b1;
    end
  end
`endif

  // An empty way always beats the policy choice.
  always_comb begin
    victim = pol_way;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_vec[w])
        victim = WAY_W'(w);
  end

endmodule

// File: rtl/dcache_assoc_ctrl.sv
// N-way set-associative write-back, write-allocate data cache controller.
// Ports: CPU side (cpu_addr_i/data_i/MemRead/MemWrite -> cpu_data_o, stall),
// memory side (mem_* line transfer with one-cycle mem_ack_i), clk_i, rst_i.
// Replacement policy: DCACHE_LRU_EN (see dcache_victim_sel).
module dcache_assoc_ctrl #(
  parameter int WAYS      = 2,
  parameter int SETS      = 16,
  parameter int LINE_BITS = 256,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_W-1:0]    cpu_addr_i,
  input  logic [DATA_W-1:0]    cpu_data_i,
  input  logic                 cpu_MemRead_i,
  input  logic                 cpu_MemWrite_i,
  output logic [DATA_W-1:0]    cpu_data_o,
  output logic                 cpu_stall_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o
);
  import dcache_pkg::*;

  localparam int OFF_B = $clog2(LINE_BITS / 8);
  localparam int IDX_B = $clog2(SETS);
  localparam int TAG_B = ADDR_W - IDX_B - OFF_B;
  localparam int SEL_B = OFF_B - 2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [TAG_B-1:0]     tag_q  [WAYS][SETS];
  logic [LINE_BITS-1:0] data_q [WAYS][SETS];
  logic [WAYS-1:0]      valid_q [SETS];
  logic [WAYS-1:0]      dirty_q [SETS];

  state_t           state_q, state_d;
  logic [WAY_W-1:0] vict_q, vict, hit_way;
  logic [IDX_B-1:0] idx_q, idx;
  logic [TAG_B-1:0] tag_rq, tag;
  logic [SEL_B-1:0] sel;
  logic [WAYS-1:0]  hit_vec;
  logic             hit, req, is_wr, idle;
  logic             lk_hit, miss, fill;
  logic             unused_addr;
  logic [ADDR_W-1:0] wb_addr, rf_addr;

  assign sel = cpu_addr_i[OFF_B-1:2];
  assign idx = cpu_addr_i[OFF_B +: IDX_B];
  assign tag = cpu_addr_i[ADDR_W-1 -: TAG_B];
  assign unused_addr = ^cpu_addr_i[1:0];

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      hit_vec[w] = valid_q[idx][w] && (tag_q[w][idx] == tag);
    for (int w = WAYS - 1; w >= 0; w--)
      if (hit_vec[w])
        hit_way = WAY_W'(w);
  end

  assign hit    = |hit_vec;
  assign req    = cpu_MemRead_i | cpu_MemWrite_i;
  assign is_wr  = cpu_MemWrite_i;
  assign idle   = (state_q == IDLE);
  assign lk_hit = idle && req && hit;
  assign miss   = idle && req && !hit;
  assign fill   = (state_q == REFILL) && mem_ack_i;

  dcache_victim_sel #(
    .WAYS  (WAYS),
    .SETS  (SETS),
    .WAY_W (WAY_W),
    .IDX_B (IDX_B)
  ) u_victim (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .look_set  (idx),
    .valid_vec (valid_q[idx]),
    .hit_en    (lk_hit),
    .hit_way   (hit_way),
    .fill_en   (fill),
    .fill_set  (idx_q),
    .fill_way  (vict_q),
    .victim    (vict)
  );

  assign wb_addr = ADDR_W'(line_addr(64'(tag_q[vict_q][idx_q]),
                                     64'(idx_q), IDX_B, OFF_B));
  assign rf_addr = ADDR_W'(line_addr(64'(tag_rq),
                                     64'(idx_q), IDX_B, OFF_B));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (miss)
          state_d = dirty_q[idx][vict] ? WB : REFILL;
      WB:
        if (mem_ack_i) state_d = WB_GAP;
      WB_GAP:
        state_d = REFILL;
      REFILL:
        if (mem_ack_i) state_d = FILL_DONE;
      FILL_DONE:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    unique case (1'b1)
      state_q == WB: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = wb_addr;
        mem_data_o   = data_q[vict_q][idx_q];
      end
      state_q == REFILL: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = rf_addr;
      end
      default: ;
    endcase
  end

  // Gated by reset so a held request cannot stall a cache in reset.
  assign cpu_stall_o = rst_i && (!idle || miss);

  always_comb begin
    cpu_data_o = '0;
    if (rst_i && lk_hit && !is_wr)
      cpu_data_o = data_q[hit_way][idx][sel*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      vict_q  <= '0;
      idx_q   <= '0;
      tag_rq  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (miss) begin
        vict_q <= vict;
        idx_q  <= idx;
        tag_rq <= tag;
      end
      if (lk_hit && is_wr)
        dirty_q[idx][hit_way] <= 1'b1;
      if (fill) begin
        valid_q[idx_q][vict_q] <= 1'b1;
        dirty_q[idx_q][vict_q] <= 1'b0;
      end
    end
  end

  // Payload arrays carry no reset; valid bits guard them.
  always_ff @(posedge clk_i) begin
    if (lk_hit && is_wr)
      data_q[hit_way][idx][sel*DATA_W +: DATA_W] <= cpu_data_i;
    if (fill) begin
      data_q[vict_q][idx_q] <= mem_data_i;
      tag_q[vict_q][idx_q]  <= tag_rq;
    end
  end

endmodule

// File: tb/tb_dcache_assoc_ctrl.sv
// Self-checking bench for dcache_assoc_ctrl (WAYS=2, SETS=16).
// Directed table, hand sequences, and random traffic against a line model.
module tb_dcache_assoc_ctrl;

  localparam int WAYS = 2;
  localparam int SETS = 16;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic         cpu_MemRead_i;
  logic         cpu_MemWrite_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o;
  logic         mem_write_o;

  dcache_assoc_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_data_i     (cpu_data_i),
    .cpu_MemRead_i  (cpu_MemRead_i),
    .cpu_MemWrite_i (cpu_MemWrite_i),
    .cpu_data_o     (cpu_data_o),
    .cpu_stall_o    (cpu_stall_o),
    .mem_data_i     (mem_data_i),
    .mem_ack_i      (mem_ack_i),
    .mem_data_o     (mem_data_o),
    .mem_addr_o     (mem_addr_o),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;

  logic [255:0] tb_mem [logic [31:0]];
  logic [255:0] m_mem  [logic [31:0]];

  logic [31:0]  tx_addr  [4];
  bit           tx_wr    [4];
  logic [255:0] tx_line  [4];
  int           tx_start [4];
  int           tx_ack   [4];
  int           ntx;

  bit           m_valid [SETS][WAYS];
  bit           m_dirty [SETS][WAYS];
  logic [22:0]  m_tag   [SETS][WAYS];
  logic [255:0] m_data  [SETS][WAYS];
  int           m_order [SETS][WAYS];
  int           m_ptr   [SETS];
  logic [31:0]  e_tx_addr [2];
  bit           e_tx_wr   [2];
  logic [255:0] e_wb_line;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          rd;
    bit          wr;
    int          dly;
    int          stalls;
    int          ntx;
    logic [31:0] tx0_addr;
    bit          tx0_wr;
    logic [31:0] txl_addr;
    logic [31:0] rdata;
    logic [31:0] wb2;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] line_init(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++)
      l[i*32 +: 32] = (a == 32'h100) ? 32'h11111111 * (i + 1)
                                     : {a[15:0], 16'hA000} + 32'(i);
    return l;
  endfunction

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    cpu_MemRead_i = 1'b0;
    cpu_MemWrite_i = 1'b0;
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  // Starts just after a negedge; services memory with `dly` wait cycles.
  task automatic do_access(input logic [31:0] a, input logic [31:0] d,
                           input bit rd, input bit wr, input int dly,
                           output logic [31:0] rdata, output int stalls);
    int  cnt;
    bit  done;
    ntx = 0;
    cnt = 0;
    done = 0;
    stalls = 0;
    rdata = '0;
    cpu_addr_i = a;
    cpu_data_i = d;
    cpu_MemRead_i = rd;
    cpu_MemWrite_i = wr;
    for (int c = 0; c < 400 && !done; c++) begin
      #1;
      if (!cpu_stall_o) begin
        rdata = cpu_data_o;
        done = 1;
      end else begin
        stalls++;
        if (mem_enable_o) begin
          if (cnt == 0 && ntx < 4) begin
            tx_addr[ntx] = mem_addr_o;
            tx_wr[ntx] = mem_write_o;
            tx_start[ntx] = c;
          end
          if (cnt == dly) begin
            if (ntx < 4) begin
              chk("mem_addr_stable", mem_addr_o, tx_addr[ntx]);
              chk("mem_write_stable", mem_write_o, tx_wr[ntx]);
              tx_line[ntx] = mem_data_o;
              tx_ack[ntx] = c;
            end
            mem_ack_i = 1'b1;
            if (mem_write_o)
              tb_mem[mem_addr_o] = mem_data_o;
            else
              mem_data_i = tb_mem.exists(mem_addr_o) ?
                           tb_mem[mem_addr_o] : line_init(mem_addr_o);
            ntx++;
            cnt = 0;
          end else begin
            cnt++;
          end
        end else begin
          cnt = 0;
        end
        @(posedge clk_i);
        #1 mem_ack_i = 1'b0;
        mem_data_i = '0;
        @(negedge clk_i);
      end
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL access_timeout: addr %0h still stalled", a);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    cpu_MemRead_i = 1'b0;
    cpu_MemWrite_i = 1'b0;
  endtask

  task automatic m_reset();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
        m_order[s][w] = w;
      end
    end
    m_mem = tb_mem;
  endtask

  // Most-recently used way moves to the head of the set's list.
  task automatic m_touch(input int s, input int w);
    int p;
    p = 0;
    for (int j = 0; j < WAYS; j++)
      if (m_order[s][j] == w) p = j;
    for (int j = p; j > 0; j--)
      m_order[s][j] = m_order[s][j-1];
    m_order[s][0] = w;
  endtask

  task automatic m_access(input logic [31:0] a, input logic [31:0] d,
                          input bit isw, input int dly,
                          output int e_stalls, output int e_ntx,
                          output logic [31:0] e_rdata);
    int s, ws, w, v;
    logic [22:0] t;
    logic [31:0] la;
    s = int'(a[8:5]);
    ws = int'(a[4:2]);
    t = a[31:9];
    w = -1;
    e_ntx = 0;
    e_stalls = 0;
    for (int i = 0; i < WAYS; i++)
      if (m_valid[s][i] && m_tag[s][i] == t) w = i;
    if (w < 0) begin
      v = -1;
      for (int i = WAYS - 1; i >= 0; i--)
        if (!m_valid[s][i]) v = i;
      if (v < 0) begin
`ifdef DCACHE_LRU_EN
        v = m_order[s][WAYS-1];
`else
        v = m_ptr[s];
`endif
      end
      if (m_dirty[s][v]) begin
        la = {m_tag[s][v], 4'(s), 5'b0};
        m_mem[la] = m_data[s][v];
        e_wb_line = m_data[s][v];
        e_tx_addr[0] = la;
        e_tx_wr[0] = 1;
        e_ntx = 1;
        e_stalls = 2 * dly + 5;
      end else begin
        e_stalls = dly + 3;
      end
      la = {t, 4'(s), 5'b0};
      e_tx_addr[e_ntx] = la;
      e_tx_wr[e_ntx] = 0;
      e_ntx++;
      m_data[s][v] = m_mem.exists(la) ? m_mem[la] : line_init(la);
      m_valid[s][v] = 1;
      m_dirty[s][v] = 0;
      m_tag[s][v] = t;
      m_touch(s, v);
      m_ptr[s] = (m_ptr[s] + 1) % WAYS;
      w = v;
    end
    e_rdata = '0;
    if (isw) begin
      m_data[s][w][ws*32 +: 32] = d;
      m_dirty[s][w] = 1;
    end else begin
      e_rdata = m_data[s][w][ws*32 +: 32];
    end
    m_touch(s, w);
  endtask

  initial begin
    logic [31:0] rdata, e_rdata, a, d;
    int st, e_st, e_n, dly, op;
    bit rd, wr;

    tbl[0] = '{32'h100, 32'h0, 1, 0, 10, 13, 1, 32'h100, 0,
               32'h100, 32'h11111111, 32'h0};
    tbl[1] = '{32'h104, 32'h0, 1, 0, 0, 0, 0, 32'h0, 0,
               32'h0, 32'h22222222, 32'h0};
    tbl[2] = '{32'h108, 32'hDEADBEEF, 0, 1, 0, 0, 0, 32'h0, 0,
               32'h0, 32'h0, 32'h0};
    tbl[3] = '{32'h108, 32'h0, 1, 0, 0, 0, 0, 32'h0, 0,
               32'h0, 32'hDEADBEEF, 32'h0};
    tbl[4] = '{32'h300, 32'h0, 1, 0, 2, 5, 1, 32'h300, 0,
               32'h300, 32'h0300A000, 32'h0};
    tbl[5] = '{32'h500, 32'h0, 1, 0, 1, 7, 2, 32'h100, 1,
               32'h500, 32'h0500A000, 32'hDEADBEEF};

    rst_i = 1'b0;
    cpu_addr_i = '0;
    cpu_data_i = '0;
    cpu_MemRead_i = 1'b0;
    cpu_MemWrite_i = 1'b0;
    mem_data_i = '0;
    mem_ack_i = 1'b0;
    #1;
    chk("rst_stall", cpu_stall_o, 0);
    chk("rst_enable", mem_enable_o, 0);
    chk("rst_write", mem_write_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_mdata", mem_data_o, 0);
    chk("rst_cdata", cpu_data_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;

    foreach (tbl[i]) begin
      do_access(tbl[i].addr, tbl[i].wdata, tbl[i].rd, tbl[i].wr,
                tbl[i].dly, rdata, st);
      chk($sformatf("row%0d_stalls", i), st, tbl[i].stalls);
      chk($sformatf("row%0d_ntx", i), ntx, tbl[i].ntx);
      chk($sformatf("row%0d_rdata", i), rdata, tbl[i].rdata);
      if (tbl[i].ntx > 0 && ntx == tbl[i].ntx) begin
        chk($sformatf("row%0d_tx0_addr", i), tx_addr[0], tbl[i].tx0_addr);
        chk($sformatf("row%0d_tx0_wr", i), tx_wr[0], tbl[i].tx0_wr);
        chk($sformatf("row%0d_txl_addr", i), tx_addr[ntx-1],
            tbl[i].txl_addr);
      end
      if (tbl[i].ntx == 2 && ntx == 2) begin
        chk($sformatf("row%0d_wb_word2", i), tx_line[0][64 +: 32],
            tbl[i].wb2);
        chk($sformatf("row%0d_gap", i), tx_start[1] - tx_ack[0] - 1, 1);
        chk($sformatf("row%0d_tx1_wr", i), tx_wr[1], 0);
      end
    end

    do_reset();
    do_access(32'h100, 0, 1, 0, 0, rdata, st);
    do_access(32'h300, 0, 1, 0, 0, rdata, st);
    do_access(32'h100, 0, 1, 0, 0, rdata, st);
    chk("pol_hit100_stalls", st, 0);
    do_access(32'h500, 0, 1, 0, 0, rdata, st);
    chk("pol_500_ntx", ntx, 1);
    chk("pol_500_addr", tx_addr[0], 32'h500);
    chk("pol_500_wr", tx_wr[0], 0);
`ifdef DCACHE_LRU_EN
    do_access(32'h100, 0, 1, 0, 0, rdata, st);
    chk("lru_100_stalls", st, 0);
    chk("lru_100_rdata", rdata, 32'h11111111);
`else
    do_access(32'h300, 0, 1, 0, 0, rdata, st);
    chk("rr_300_stalls", st, 0);
    do_access(32'h100, 0, 1, 0, 0, rdata, st);
    chk("rr_100_stalls", st, 3);
`endif

    do_reset();
    cpu_addr_i = 32'h100;
    cpu_MemRead_i = 1'b1;
    cpu_MemWrite_i = 1'b0;
    #1;
    chk("mid_miss_stall", cpu_stall_o, 1);
    chk("mid_idle_enable", mem_enable_o, 0);
    @(negedge clk_i);
    #1;
    chk("mid_refill_enable", mem_enable_o, 1);
    chk("mid_refill_write", mem_write_o, 0);
    chk("mid_refill_addr", mem_addr_o, 32'h100);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("mid_rst_enable", mem_enable_o, 0);
    chk("mid_rst_stall", cpu_stall_o, 0);
    chk("mid_rst_write", mem_write_o, 0);
    chk("mid_rst_addr", mem_addr_o, 0);
    chk("mid_rst_mdata", mem_data_o, 0);
    chk("mid_rst_cdata", cpu_data_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    cpu_MemRead_i = 1'b0;
    do_access(32'h100, 0, 1, 0, 0, rdata, st);
    chk("post_rst_stalls", st, 3);
    chk("post_rst_ntx", ntx, 1);
    chk("post_rst_addr", tx_addr[0], 32'h100);
    chk("post_rst_rdata", rdata, 32'h11111111);

    do_reset();
    m_reset();
    for (int k = 0; k < 300; k++) begin
      a = (32'($urandom_range(0, 4)) << 9)
        | (($urandom_range(0, 1) != 0) ? 32'h100 : 32'h60)
        | (32'($urandom_range(0, 7)) << 2);
      d = $urandom;
      dly = $urandom_range(0, 3);
      op = $urandom_range(0, 3);
      rd = (op != 2);
      wr = (op >= 2);
      m_access(a, d, wr, dly, e_st, e_n, e_rdata);
      do_access(a, d, rd, wr, dly, rdata, st);
      chk("rnd_stalls", st, e_st);
      chk("rnd_ntx", ntx, e_n);
      chk("rnd_rdata", rdata, e_rdata);
      for (int i = 0; i < e_n && i < ntx; i++) begin
        chk("rnd_tx_addr", tx_addr[i], e_tx_addr[i]);
        chk("rnd_tx_wr", tx_wr[i], e_tx_wr[i]);
      end
      if (e_n == 2 && ntx == 2)
        chk("rnd_wb_line", tx_line[0], e_wb_line);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
